// File: rtl/dmem_interconnect.sv
// dmem_interconnect: routes one core data-memory port to NUM_SLAVES targets selected by the top address bits.
// Each access waits for the selected slave's ready, with a timeout watchdog and a sticky bus-error report.
module dmem_interconnect #(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_BITS = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [31:0]             dmem_address,
  input  logic                    dmem_enable,
  input  logic [31:0]             dmem_write_data,
  input  logic                    dmem_write_enable,
  input  logic [2:0]              dmem_write_mode,
  input  logic                    dmem_read_enable,
  input  logic [2:0]              dmem_read_mode,
  output logic [31:0]             dmem_read_data,
  output logic                    dmem_wait,
  output logic [NUM_SLAVES-1:0]   s_enable,
  output logic [31:0]             s_address,
  output logic [31:0]             s_write_data,
  output logic                    s_write_enable,
  output logic [2:0]              s_write_mode,
  output logic                    s_read_enable,
  output logic [2:0]              s_read_mode,
  input  logic [32*NUM_SLAVES-1:0] s_read_data,
  input  logic [NUM_SLAVES-1:0]   s_ready,
  input  logic                    err_clear,
  output logic                    bus_error,
  output logic [31:0]             error_address
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, ERROR = 2'd2, RESPOND = 2'd3;
  logic [1:0] state;
  logic [15:0] count;
  logic [SEL_BITS-1:0] sel;
  logic [NUM_SLAVES-1:0] onehot;
  logic [31:0] rdata;
  logic req, mapped, hit;
  assign sel = dmem_address[31 -: SEL_BITS];
  assign mapped = 32'(sel) < 32'(NUM_SLAVES);
  assign req = dmem_enable & (dmem_write_enable | dmem_read_enable);
  assign hit = |(s_ready & s_enable);
  assign dmem_wait = dmem_enable & (state != RESPOND);
  // s_enable is one-hot, so it doubles as the read-data mux select
  always_comb begin
    onehot = '0;
    rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      onehot[i] = sel == SEL_BITS'(i);
      if (s_enable[i]) rdata = s_read_data[32*i +: 32];
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      s_enable <= '0;
      s_address <= '0;
      s_write_data <= '0;
      s_write_enable <= 1'b0;
      s_write_mode <= '0;
      s_read_enable <= 1'b0;
      s_read_mode <= '0;
      dmem_read_data <= '0;
      bus_error <= 1'b0;
      error_address <= '0;
    end else begin
      if (err_clear) begin
        bus_error <= 1'b0;
        error_address <= '0;
      end
      case (state)
        IDLE: if (req) begin
          s_address <= dmem_address;
          s_write_data <= dmem_write_data;
          s_write_enable <= dmem_write_enable;
          s_write_mode <= dmem_write_mode;
          s_read_enable <= dmem_read_enable & ~dmem_write_enable;
          s_read_mode <= dmem_read_mode;
          count <= '0;
          s_enable <= mapped ? onehot : '0;
          state <= mapped ? ACCESS : ERROR;
        end
        ACCESS: if (hit) begin
          dmem_read_data <= s_read_enable ? rdata : '0;
          s_enable <= '0;
          state <= RESPOND;
        end else if (count == 16'(TIMEOUT - 1)) begin
          s_enable <= '0;
          state <= ERROR;
        end else count <= count + 16'd1;
        // a new error beats a same-cycle clear
        ERROR: begin
          dmem_read_data <= '0;
          s_enable <= '0;
          if (!bus_error || err_clear) begin
            bus_error <= 1'b1;
            error_address <= s_address;
          end
          state <= RESPOND;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_interconnect.sv
// tb_dmem_interconnect: table vectors, hand-written corner sequences and random accesses
// checked against a transaction-level model of latency, data and error reporting.
`timescale 1ns/1ps
module tb_dmem_interconnect;
  localparam int NS = 4, TO = 8;
  logic clk = 0, reset_n = 0;
  logic [31:0] dmem_address = 0, dmem_write_data = 0, dmem_read_data, s_address, s_write_data, error_address;
  logic dmem_enable = 0, dmem_write_enable = 0, dmem_read_enable = 0, dmem_wait;
  logic [2:0] dmem_write_mode = 0, dmem_read_mode = 0, s_write_mode, s_read_mode;
  logic [NS-1:0] s_enable, s_ready = 0;
  logic s_write_enable, s_read_enable, bus_error, err_clear = 0;
  logic [32*NS-1:0] s_read_data = 0;
  int errors = 0, checks = 0;
  logic exp_err;
  logic [31:0] exp_eaddr;

  dmem_interconnect #(.NUM_SLAVES(NS), .SEL_BITS(4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .dmem_address(dmem_address), .dmem_enable(dmem_enable),
    .dmem_write_data(dmem_write_data), .dmem_write_enable(dmem_write_enable),
    .dmem_write_mode(dmem_write_mode), .dmem_read_enable(dmem_read_enable),
    .dmem_read_mode(dmem_read_mode), .dmem_read_data(dmem_read_data), .dmem_wait(dmem_wait),
    .s_enable(s_enable), .s_address(s_address), .s_write_data(s_write_data),
    .s_write_enable(s_write_enable), .s_write_mode(s_write_mode), .s_read_enable(s_read_enable),
    .s_read_mode(s_read_mode), .s_read_data(s_read_data), .s_ready(s_ready),
    .err_clear(err_clear), .bus_error(bus_error), .error_address(error_address));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic we, re;
    logic [31:0] wdata;
    logic [2:0] wmode, rmode;
    int delay;
    logic [31:0] sdata;
    int lat, ena;
    logic [31:0] rdata;
    logic err;
    logic [31:0] eaddr;
  } vec_t;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // runs one access with a slave that answers 'delay' cycles after its select rises
  task automatic run(input vec_t v, input int clr_at);
    int s, cyc, ena, lat;
    logic bad;
    logic [NS-1:0] oh;
    logic [31:0] rd;
    s = int'(v.addr[31:28]);
    oh = s < NS ? NS'(1 << s) : '0;
    @(negedge clk);
    dmem_address = v.addr; dmem_write_data = v.wdata; dmem_write_enable = v.we;
    dmem_read_enable = v.re; dmem_write_mode = v.wmode; dmem_read_mode = v.rmode; dmem_enable = 1;
    s_read_data = {$urandom, $urandom, $urandom, $urandom};
    if (s < NS) s_read_data[32*s +: 32] = v.sdata;
    s_ready = NS'($urandom) & ~oh;
    cyc = 0; ena = 0; lat = -1; bad = 0; rd = 0;
    while (lat < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      err_clear = cyc == clr_at;
      if (s_enable != 0) begin
        ena++;
        if (s_enable !== oh || s_address !== v.addr || s_write_data !== v.wdata ||
            s_write_enable !== v.we || s_read_enable !== (v.re & ~v.we) ||
            s_write_mode !== v.wmode || s_read_mode !== v.rmode) bad = 1;
      end
      s_ready = (s_enable != 0 && ena - 1 == v.delay) ? oh : (NS'($urandom) & ~oh);
      if (!dmem_wait) begin
        lat = cyc;
        rd = dmem_read_data;
      end
    end
    if (lat < 0) $display("FAIL timeout: no RESPOND within %0d cycles for %h", cyc, v.addr);
    check("latency", lat, v.lat);
    check("enable_cycles", ena, v.ena);
    check("stable_s_outputs", bad, 0);
    check("read_data", rd, v.rdata);
    check("bus_error", bus_error, v.err);
    check("error_address", error_address, v.eaddr);
    dmem_enable = 0; s_ready = 0; err_clear = 0;
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    logic bad;
    int cnt;
    tbl[0] = '{32'h1000_0010, 0, 1, 32'h0, 3'd0, 3'd2, 0, 32'hDEADBEEF, 2, 1, 32'hDEADBEEF, 0, 32'h0};
    tbl[1] = '{32'h0000_0100, 1, 0, 32'h0000_00AA, 3'd0, 3'd0, 5, 32'h5555_5555, 7, 6, 32'h0, 0, 32'h0};
    tbl[2] = '{32'hF000_0000, 0, 1, 32'h0, 3'd0, 3'd2, 0, 32'h0, 2, 0, 32'h0, 1, 32'hF000_0000};
    tbl[3] = '{32'h2000_0040, 0, 1, 32'h0, 3'd0, 3'd4, 99, 32'hCAFE_F00D, 10, 8, 32'h0, 1, 32'hF000_0000};
    tbl[4] = '{32'h3000_0004, 1, 1, 32'h1234_0000, 3'd1, 3'd5, 1, 32'h7777_7777, 3, 2, 32'h0, 1, 32'hF000_0000};
    tbl[5] = '{32'h4000_0000, 0, 1, 32'h0, 3'd0, 3'd0, 0, 32'h0, 2, 0, 32'h0, 1, 32'hF000_0000};
    repeat (2) @(negedge clk);
    check("reset_s_enable", s_enable, 0);
    check("reset_read_data", dmem_read_data, 0);
    check("reset_bus_error", bus_error, 0);
    check("reset_error_address", error_address, 0);
    check("reset_s_address", s_address, 0);
    reset_n = 1;
    for (int i = 0; i < 6; i++) run(tbl[i], -1);
    // clearing the sticky error
    @(negedge clk); err_clear = 1;
    @(negedge clk); err_clear = 0;
    check("clear_bus_error", bus_error, 0);
    check("clear_error_address", error_address, 0);
    // first error latched, then a new error coinciding with err_clear replaces it
    run('{32'h5000_0000, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 1, 32'h5000_0000}, -1);
    run('{32'h6000_0008, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 1, 32'h6000_0008}, 1);
    // reset in the middle of an access
    @(negedge clk);
    dmem_address = 32'h2000_0000; dmem_read_enable = 1; dmem_write_enable = 0; dmem_enable = 1; s_ready = 0;
    repeat (3) @(negedge clk);
    check("mid_access_enable", s_enable, 4'b0100);
    reset_n = 0;
    @(negedge clk);
    check("reset_abort_enable", s_enable, 0);
    check("reset_abort_bus_error", bus_error, 0);
    check("reset_abort_wait", dmem_wait, 1);
    reset_n = 1; dmem_enable = 0;
    run('{32'h2000_0008, 0, 1, 0, 0, 3'd2, 2, 32'h1234_5678, 4, 3, 32'h1234_5678, 0, 0}, -1);
    // enable without read or write is never served
    @(negedge clk);
    dmem_enable = 1; dmem_read_enable = 0; dmem_write_enable = 0; bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (!dmem_wait || s_enable != 0) bad = 1;
    end
    check("no_op_request", bad, 0);
    dmem_enable = 0;
    // master drops enable mid-access; the access still completes on the slave side
    @(negedge clk);
    dmem_address = 32'h1000_0000; dmem_read_enable = 1; dmem_enable = 1; cnt = 0; bad = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (s_enable == 4'b0010) cnt++;
      if (i > 2 && dmem_wait) bad = 1;
      if (i == 2) dmem_enable = 0;
      s_ready = (s_enable != 0 && cnt == 5) ? 4'b0010 : 4'b0000;
    end
    s_ready = 0;
    check("dropped_enable_cycles", cnt, 5);
    check("dropped_no_wait", bad, 0);
    run('{32'h0000_0020, 0, 1, 0, 0, 0, 0, 32'hA5A5_0001, 2, 1, 32'hA5A5_0001, 0, 0}, -1);
    // random accesses against the transaction model
    exp_err = 0; exp_eaddr = 0;
    for (int i = 0; i < 30; i++) begin
      int sel, m;
      logic mapped, tout;
      sel = $urandom_range(0, 5);
      m = $urandom_range(1, 3);
      v.addr = {4'(sel), 28'($urandom)};
      v.we = m[0]; v.re = m[1];
      v.wdata = $urandom; v.wmode = 3'($urandom); v.rmode = 3'($urandom);
      v.delay = $urandom_range(0, 10); v.sdata = $urandom;
      mapped = sel < NS;
      tout = mapped && v.delay >= TO;
      v.ena = !mapped ? 0 : tout ? TO : v.delay + 1;
      v.lat = v.ena + 1 + ((!mapped || tout) ? 1 : 0);
      v.rdata = (mapped && !tout && v.re && !v.we) ? v.sdata : 32'h0;
      if ((!mapped || tout) && !exp_err) begin
        exp_err = 1;
        exp_eaddr = v.addr;
      end
      v.err = exp_err; v.eaddr = exp_eaddr;
      run(v, -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
